// File: rtl/detection_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : detection_window_gen
// Description : Assembles stride-aligned WIN_ROWS x WIN_COLS detection windows
//               from a raster stream of normalized HOG blocks, with top-left
//               block coordinates and a last-window-of-frame flag.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module detection_window_gen #(
  parameter int INPUT_WIDTH      = 36,
  parameter int IMAGE_BLOCK_COLS = 40,
  parameter int IMAGE_BLOCK_ROWS = 30,
  parameter int WIN_COLS         = 4,
  parameter int WIN_ROWS         = 8,
  parameter int STRIDE_X         = 1,
  parameter int STRIDE_Y         = 1,
  parameter int COORD_WIDTH      = 8,
  parameter int OUTPUT_WIDTH     = INPUT_WIDTH * WIN_COLS * WIN_ROWS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [INPUT_WIDTH-1:0]  normalized_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] detection_window,
  output logic [COORD_WIDTH-1:0]  out_x,
  output logic [COORD_WIDTH-1:0]  out_y,
  output logic                    out_last
);

  localparam int c_cw  = (IMAGE_BLOCK_COLS > 1) ? $clog2(IMAGE_BLOCK_COLS) : 1;
  localparam int c_rw  = (IMAGE_BLOCK_ROWS > 1) ? $clog2(IMAGE_BLOCK_ROWS) : 1;
  localparam int c_pxw = (STRIDE_X > 1) ? $clog2(STRIDE_X) : 1;
  localparam int c_pyw = (STRIDE_Y > 1) ? $clog2(STRIDE_Y) : 1;
  localparam int c_lbn = WIN_ROWS - 1;

  localparam logic [c_cw-1:0]        c_col_max   = c_cw'(IMAGE_BLOCK_COLS - 1);
  localparam logic [c_rw-1:0]        c_row_max   = c_rw'(IMAGE_BLOCK_ROWS - 1);
  localparam logic [c_cw-1:0]        c_col_first = c_cw'(WIN_COLS - 1);
  localparam logic [c_rw-1:0]        c_row_first = c_rw'(WIN_ROWS - 1);
  localparam logic [c_pxw-1:0]       c_phx_max   = c_pxw'(STRIDE_X - 1);
  localparam logic [c_pyw-1:0]       c_phy_max   = c_pyw'(STRIDE_Y - 1);
  localparam logic [COORD_WIDTH-1:0] c_last_x    =
    COORD_WIDTH'(((IMAGE_BLOCK_COLS - WIN_COLS) / STRIDE_X) * STRIDE_X);
  localparam logic [COORD_WIDTH-1:0] c_last_y    =
    COORD_WIDTH'(((IMAGE_BLOCK_ROWS - WIN_ROWS) / STRIDE_Y) * STRIDE_Y);

  // Position counters and stride phases describe the next block to arrive.
  logic [c_cw-1:0]  r_col, w_col, w_col_nxt;
  logic [c_rw-1:0]  r_row, w_row, w_row_nxt;
  logic [c_pxw-1:0] r_phx, w_phx, w_phx_nxt;
  logic [c_pyw-1:0] r_phy, w_phy, w_phy_nxt;
  logic             w_col_wrap, w_row_wrap;
  logic             w_accept, w_emit, w_last;
  logic [COORD_WIDTH-1:0] w_x, w_y;

  logic                    r_out_valid, r_out_last;
  logic [COORD_WIDTH-1:0]  r_out_x, r_out_y;
  logic [OUTPUT_WIDTH-1:0] r_window, w_pack;

  logic [INPUT_WIDTH-1:0] r_win     [WIN_ROWS][WIN_COLS];
  logic [INPUT_WIDTH-1:0] w_win_nxt [WIN_ROWS][WIN_COLS];
  logic [INPUT_WIDTH-1:0] w_lb_rd   [c_lbn];
  logic [INPUT_WIDTH-1:0] w_lb_wr   [c_lbn];

  assign in_ready         = !r_out_valid || out_ready;
  assign w_accept         = in_valid && in_ready;
  assign out_valid        = r_out_valid;
  assign out_last         = r_out_last;
  assign out_x            = r_out_x;
  assign out_y            = r_out_y;
  assign detection_window = r_window;

  // A start-of-frame block is placed at (0,0) whatever the counters say.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_phx      = in_sof ? '0 : r_phx;
  assign w_phy      = in_sof ? '0 : r_phy;
  assign w_col_wrap = (w_col == c_col_max);
  assign w_row_wrap = (w_row == c_row_max);

  // Phase zero marks stride-aligned positions, so no divider is needed.
  assign w_emit = (w_col >= c_col_first) && (w_row >= c_row_first) &&
                  (w_phx == '0) && (w_phy == '0);
  assign w_x    = COORD_WIDTH'(w_col - c_col_first);
  assign w_y    = COORD_WIDTH'(w_row - c_row_first);
  assign w_last = (w_x == c_last_x) && (w_y == c_last_y);

  // Next raster position; phases only run once the window origin is in range.
  always_comb begin
    w_col_nxt = w_col_wrap ? '0 : w_col + 1'b1;
    w_row_nxt = w_row;
    w_phx_nxt = '0;
    w_phy_nxt = w_phy;
    if (!w_col_wrap && (w_col >= c_col_first))
      w_phx_nxt = (w_phx == c_phx_max) ? '0 : w_phx + 1'b1;
    if (w_col_wrap) begin
      w_row_nxt = w_row_wrap ? '0 : w_row + 1'b1;
      w_phy_nxt = '0;
      if (!w_row_wrap && (w_row >= c_row_first))
        w_phy_nxt = (w_phy == c_phy_max) ? '0 : w_phy + 1'b1;
    end
  end

  // Line buffers shift down one row at the current column; newest row at the bottom.
  always_comb begin
    for (int k = 0; k < c_lbn; k++) w_lb_wr[k] = normalized_block;
    for (int k = 0; k < c_lbn - 1; k++) w_lb_wr[k] = w_lb_rd[k + 1];
  end

  for (genvar k = 0; k < c_lbn; k++) begin : g_lb
    logic [INPUT_WIDTH-1:0] r_mem [IMAGE_BLOCK_COLS];
    assign w_lb_rd[k] = r_mem[w_col];
    // Storage only; stale contents are masked by the emission gating.
    always_ff @(posedge clk) begin
      if (w_accept) r_mem[w_col] <= w_lb_wr[k];
    end
  end

  // Window shifts left; the new right column is the buffered column plus the new block.
  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < WIN_ROWS; r++)
      for (int c = 0; c < WIN_COLS - 1; c++)
        w_win_nxt[r][c] = r_win[r][c + 1];
    for (int r = 0; r < WIN_ROWS - 1; r++)
      w_win_nxt[r][WIN_COLS - 1] = w_lb_rd[r];
    w_win_nxt[WIN_ROWS - 1][WIN_COLS - 1] = normalized_block;
  end

  // Flatten the window row-major, top-left element in the low bits.
  always_comb begin
    w_pack = '0;
    for (int r = 0; r < WIN_ROWS; r++)
      for (int c = 0; c < WIN_COLS; c++)
        w_pack[(r * WIN_COLS + c) * INPUT_WIDTH +: INPUT_WIDTH] = w_win_nxt[r][c];
  end

  // Counters, window array and output register; output holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_phx       <= '0;
      r_phy       <= '0;
      r_win       <= '{default: '0};
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_window    <= '0;
    end else if (w_accept) begin
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_phx       <= w_phx_nxt;
      r_phy       <= w_phy_nxt;
      r_win       <= w_win_nxt;
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_window   <= w_pack;
        r_out_x    <= w_x;
        r_out_y    <= w_y;
        r_out_last <= w_last;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detection_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_detection_window_gen
// Description : Self-checking bench for detection_window_gen (6x4 blocks,
//               2x3 window) with a scoreboard fed from an image model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detection_window_gen;

  localparam int IW   = 36;
  localparam int COLS = 6;
  localparam int ROWS = 4;
  localparam int WC   = 2;
  localparam int WR   = 3;
  localparam int CW   = 8;
  localparam int OW   = IW * WC * WR;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
    logic [OW-1:0] win;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b1;
  logic [IW-1:0] blk = '0;

  logic          a_in_ready, a_out_valid, a_out_last;
  logic [OW-1:0] a_win;
  logic [CW-1:0] a_x, a_y;
  logic          b_in_ready, b_out_valid, b_out_last;
  logic [OW-1:0] b_win;
  logic [CW-1:0] b_x, b_y;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   a_wins = 0, a_lasts = 0, b_wins = 0, b_lasts = 0;
  int   a_lx = -1, a_ly = -1;
  bit   b_en = 1'b1;
  logic [IW-1:0] img [ROWS][COLS];
  int   mcol = 0, mrow = 0;

  always #5 clk = ~clk;

  detection_window_gen #(
    .INPUT_WIDTH(IW), .IMAGE_BLOCK_COLS(COLS), .IMAGE_BLOCK_ROWS(ROWS),
    .WIN_COLS(WC), .WIN_ROWS(WR), .STRIDE_X(1), .STRIDE_Y(1), .COORD_WIDTH(CW)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sof(in_sof), .normalized_block(blk), .out_valid(a_out_valid),
    .out_ready(out_ready), .detection_window(a_win), .out_x(a_x), .out_y(a_y),
    .out_last(a_out_last)
  );

  detection_window_gen #(
    .INPUT_WIDTH(IW), .IMAGE_BLOCK_COLS(COLS), .IMAGE_BLOCK_ROWS(ROWS),
    .WIN_COLS(WC), .WIN_ROWS(WR), .STRIDE_X(2), .STRIDE_Y(1), .COORD_WIDTH(CW)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sof(in_sof), .normalized_block(blk), .out_valid(b_out_valid),
    .out_ready(out_ready), .detection_window(b_win), .out_x(b_x), .out_y(b_y),
    .out_last(b_out_last)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected window from the image model at origin (x,y) for horizontal stride sx.
  function automatic exp_t make_exp(input int x, input int y, input int sx);
    exp_t e;
    e.x    = CW'(x);
    e.y    = CW'(y);
    e.last = (x == ((COLS - WC) / sx) * sx) && (y == (ROWS - WR));
    e.win  = '0;
    for (int r = 0; r < WR; r++)
      for (int c = 0; c < WC; c++)
        e.win[(r * WC + c) * IW +: IW] = img[y + r][x + c];
    return e;
  endfunction

  task automatic model_accept(input logic [IW-1:0] d, input bit sof);
    if (sof) begin
      mcol = 0;
      mrow = 0;
    end
    img[mrow][mcol] = d;
    if (mcol >= WC - 1 && mrow >= WR - 1) begin
      qa.push_back(make_exp(mcol - WC + 1, mrow - WR + 1, 1));
      if (b_en && ((mcol - WC + 1) % 2 == 0))
        qb.push_back(make_exp(mcol - WC + 1, mrow - WR + 1, 2));
    end
    if (mcol == COLS - 1) begin
      mcol = 0;
      mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the block is accepted.
  task automatic send_block(input logic [IW-1:0] d, input bit sof);
    int guard;
    bit done;
    guard    = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    blk      = d;
    in_sof   = sof;
    while (!done) begin
      @(negedge clk);
      if (a_in_ready) begin
        model_accept(d, sof);
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 100) begin
          chk("in_ready_timeout", a_in_ready, 1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit sof_first);
    for (int i = 0; i < COLS * ROWS; i++)
      send_block(IW'(base + i), sof_first && (i == 0));
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((qa.size() != 0 || (b_en && qb.size() != 0)) && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(tag, qa.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every handshaken window must match the oldest expected entry.
  always @(negedge clk) begin
    if (a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        chk("a_spurious_window", a_out_valid, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_x", a_x, ea.x);
        chk("a_y", a_y, ea.y);
        chk("a_last", a_out_last, ea.last);
        chk("a_window", a_win, ea.win);
        a_wins++;
        if (a_out_last) begin
          a_lasts++;
          a_lx = int'(a_x);
          a_ly = int'(a_y);
        end
      end
    end
    if (b_en && b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        chk("b_spurious_window", b_out_valid, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_x", b_x, eb.x);
        chk("b_y", b_y, eb.y);
        chk("b_last", b_out_last, eb.last);
        chk("b_window", b_win, eb.win);
        b_wins++;
        if (b_out_last) b_lasts++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_out_x", a_x, 0);
    chk("rst_out_y", a_y, 0);
    chk("rst_window", a_win, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk);
    #1;

    // Full frame, stride 1 on A and stride 2 on B
    send_frame(0, 1'b1);
    drain("t1_drain");
    chk("t1_win_count", a_wins, 10);
    chk("t1_last_count", a_lasts, 1);
    chk("t1_last_x", a_lx, 4);
    chk("t1_last_y", a_ly, 1);
    chk("t2_win_count", b_wins, 6);
    chk("t2_last_count", b_lasts, 1);
    b_en = 1'b0;

    // Output stall while a window is pending
    a_wins = 0;
    a_lasts = 0;
    for (int i = 0; i < 14; i++) send_block(IW'(200 + i), i == 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    blk       = IW'(214);
    repeat (5) begin
      @(negedge clk);
      chk("t3_in_ready", a_in_ready, 0);
      chk("t3_out_valid", a_out_valid, 1);
      chk("t3_window_hold", a_win, qa[0].win);
      chk("t3_x_hold", a_x, qa[0].x);
      chk("t3_y_hold", a_y, qa[0].y);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 14; i < 24; i++) send_block(IW'(200 + i), 1'b0);
    drain("t3_drain");
    chk("t3_win_count", a_wins, 10);
    chk("t3_last_count", a_lasts, 1);

    // Mid-frame start-of-frame
    a_wins = 0;
    for (int i = 0; i < 9; i++) send_block(IW'(300 + i), i == 0);
    for (int i = 0; i < 24; i++) begin
      if (i == 14) chk("t4_no_early_window", a_wins, 0);
      send_block(IW'(400 + i), i == 0);
    end
    drain("t4_drain");
    chk("t4_win_count", a_wins, 10);

    // Reset with a window pending
    for (int i = 0; i < 14; i++) send_block(IW'(500 + i), i == 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_pending_valid", a_out_valid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_rst", a_out_valid, 0);
    chk("t5_ready_after_rst", a_in_ready, 1);
    qa.delete();
    mcol = 0;
    mrow = 0;
    out_ready = 1'b1;
    a_wins = 0;
    @(posedge clk);
    #1;
    send_frame(600, 1'b0);
    drain("t5_drain");
    chk("t5_win_count", a_wins, 10);

    // Two back-to-back frames
    a_wins = 0;
    a_lasts = 0;
    send_frame(700, 1'b1);
    send_frame(800, 1'b1);
    drain("t6_drain");
    chk("t6_win_count", a_wins, 20);
    chk("t6_last_count", a_lasts, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/detection_window_gen.md
Name: detection_window_gen

Overview:
Parametrised successor to the fixed 64x128 detection-window assembler. Consumes the raster stream of normalized HOG blocks and emits every stride-aligned WIN_ROWS x WIN_COLS block window, with its top-left block coordinate and an end-of-frame flag. Contains its own block line buffer, window register array and output register. Sits between block normalization and the SVM classifier.

Parameters:
INPUT_WIDTH, 36, bits per normalized block
IMAGE_BLOCK_COLS, 40, blocks per image row (640/16)
IMAGE_BLOCK_ROWS, 30, block rows per frame (480/16)
WIN_COLS, 4, window width in blocks (>=1, <=IMAGE_BLOCK_COLS)
WIN_ROWS, 8, window height in blocks (>=2, <=IMAGE_BLOCK_ROWS)
STRIDE_X, 1, horizontal window step in blocks (>=1)
STRIDE_Y, 1, vertical window step in blocks (>=1)
COORD_WIDTH, 8, width of coordinate outputs
OUTPUT_WIDTH, INPUT_WIDTH*WIN_COLS*WIN_ROWS, window bus width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  block valid
in_ready  out  1  block accepted when in_valid & in_ready
in_sof  in  1  qualifies accepted block as frame (0,0)
normalized_block  in  INPUT_WIDTH  block data
out_valid  out  1  window valid
out_ready  in  1  consumer ready
detection_window  out  OUTPUT_WIDTH  window data
out_x  out  COORD_WIDTH  top-left block column of window
out_y  out  COORD_WIDTH  top-left block row of window
out_last  out  1  last emitted window of frame

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset: out_valid=0, out_last=0, out_x=0, out_y=0, detection_window=0; col/row counters and stride phases=0. in_ready is therefore 1 the cycle after reset. Line-buffer RAM is not reset.
- in_ready = !out_valid | out_ready (combinational). Output register is held stable while out_valid & !out_ready.
- Counters: col 0..IMAGE_BLOCK_COLS-1, row 0..IMAGE_BLOCK_ROWS-1, advanced per accepted block. col wraps to 0 and row increments; at (last col, last row) both wrap to 0 (next frame).
- in_sof on an accepted block forces that block to (col=0,row=0) regardless of counters. Mid-frame sof abandons the partial frame; a pending output is unaffected.
- Storage: WIN_ROWS-1 line buffers of IMAGE_BLOCK_COLS entries plus a WIN_ROWS x WIN_COLS window array. On accept, the window shifts one column left. The new right column is the line-buffer entries at current col (oldest row at top) plus the incoming block at bottom. Line buffers shift down one row at that col.
- Emission: accepted block at (col,row) produces a window iff col>=WIN_COLS-1, row>=WIN_ROWS-1, (col-WIN_COLS+1)%STRIDE_X==0 and (row-WIN_ROWS+1)%STRIDE_Y==0. Implement the modulo with phase counters, not dividers.
- Latency: 1 cycle. Block accepted at cycle t gives out_valid=1 at t+1, with a window including that block. If no emission and out_ready is high, out_valid drops.
- out_x = col-WIN_COLS+1, out_y = row-WIN_ROWS+1 of the triggering block.
- Packing: element (r,c), r=0 top row, c=0 left column, occupies bits [(r*WIN_COLS+c)*INPUT_WIDTH +: INPUT_WIDTH].
- out_last=1 iff out_x==LAST_X and out_y==LAST_Y. LAST_X = ((IMAGE_BLOCK_COLS-WIN_COLS)/STRIDE_X)*STRIDE_X; LAST_Y is computed likewise.
- Windows never span image-row or frame boundaries; the col/row gating guarantees this even though line buffers hold stale data.

Test Plan:
- Params COLS=6, ROWS=4, WIN 2x3, stride 1; blocks value=row*6+col, out_ready=1, 24 blocks -> exactly 10 windows. First window one cycle after block 13: out_x=0, out_y=0, elements (0,0)=0, (0,1)=1, (1,0)=6, (1,1)=7, (2,0)=12, (2,1)=13. Last window has x=4, y=1, out_last=1.
- Same, STRIDE_X=2 -> 6 windows with x in {0,2,4}, y in {0,1}; out_last only on (4,1).
- out_ready=0 for 5 cycles while a window is pending -> in_ready=0; detection_window, out_x and out_y are stable. After release, the window sequence is identical to the unstalled run and no block is lost.
- in_sof asserted on block 9 mid-frame -> counters restart. No window until the 14th block after sof, and that window is at (0,0) containing only post-sof data.
- rst asserted mid-frame with out_valid=1 -> next cycle out_valid=0, in_ready=1. A new frame after reset produces a correct first window.
- Two back-to-back frames with no gap, in_sof on each first block -> both frames yield identical 10-window coordinate sequences. No window mixes blocks from both frames.
